// File: rtl/ysyx_25040105_lsu_if.sv
// Bundle of the LSU's upstream (EXU), downstream (WBU) and data-bus signals.
// The master modport is the LSU itself. The slave modport is its environment.
interface ysyx_25040105_lsu_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic [31:0] rs2_data;
  logic [3:0]  mem_op;
  logic [4:0]  rd_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    input  in_valid, alu_result, rs2_data, mem_op, rd_in, out_ready,
           mem_gnt, mem_rvalid, mem_rdata,
    output in_ready, out_valid, out_data, out_rd, out_err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
  );

  modport slave (
    output in_valid, alu_result, rs2_data, mem_op, rd_in, out_ready,
           mem_gnt, mem_rvalid, mem_rdata,
    input  in_ready, out_valid, out_data, out_rd, out_err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/ysyx_25040105_lsu.sv
// Non-pipelined load/store unit: one instruction in flight, one bus access per
// instruction, with a watchdog covering the bus phases REQ and WAIT.
module ysyx_25040105_lsu #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  ysyx_25040105_lsu_if.master       io,
  output logic [1:0]                dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Senders hold payload stable while valid && !ready. mem_req/mem_gnt is the
  // same rule on the bus. mem_rvalid is a one-cycle push with no back-pressure.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT_CYC);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sdata_q, sdata_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_err_q, out_err_d;
  logic [31:0] wdog_q, wdog_d;

  logic [1:0]  lane;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_val;
  logic [31:0] wdata_lane;
  logic [3:0]  wmask_lane;
  logic        timeout_hit;
  logic        req_active;

  function automatic logic is_load(input logic [3:0] op);
    return op inside {4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101};
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return op inside {4'b1001, 4'b1010, 4'b1011};
  endfunction

  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
    logic m;
    m = 1'b0;
    case (op)
      4'b0010, 4'b0101, 4'b1010: m = a[0];
      4'b0011, 4'b1011:          m = |a;
      default:                   m = 1'b0;
    endcase
    return m;
  endfunction

  assign lane = addr_q[1:0];

  always_comb begin
    rbyte = io.mem_rdata[7:0];
    case (lane)
      2'd1:    rbyte = io.mem_rdata[15:8];
      2'd2:    rbyte = io.mem_rdata[23:16];
      2'd3:    rbyte = io.mem_rdata[31:24];
      default: rbyte = io.mem_rdata[7:0];
    endcase
    rhalf = lane[1] ? io.mem_rdata[31:16] : io.mem_rdata[15:0];
    load_val = io.mem_rdata;
    case (op_q)
      4'b0001: load_val = {{24{rbyte[7]}}, rbyte};
      4'b0010: load_val = {{16{rhalf[15]}}, rhalf};
      4'b0100: load_val = {24'd0, rbyte};
      4'b0101: load_val = {16'd0, rhalf};
      default: load_val = io.mem_rdata;
    endcase
  end

  always_comb begin
    wdata_lane = sdata_q;
    wmask_lane = 4'b1111;
    case (op_q[1:0])
      2'b01: begin
        wdata_lane = {4{sdata_q[7:0]}};
        wmask_lane = 4'b0001 << lane;
      end
      2'b10: begin
        wdata_lane = {2{sdata_q[15:0]}};
        wmask_lane = 4'b0011 << lane;
      end
      default: begin
        wdata_lane = sdata_q;
        wmask_lane = 4'b1111;
      end
    endcase
  end

  // The abort fires in the cycle whose end completes TIMEOUT_CYC bus cycles.
  assign timeout_hit = (TIMEOUT_W != 32'd0) &&
                       ((state_q == S_REQ) || (state_q == S_WAIT)) &&
                       ((wdog_q + 32'd1) == TIMEOUT_W);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    sdata_d    = sdata_q;
    op_d       = op_q;
    rd_d       = rd_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    wdog_d     = wdog_q;
    case (state_q)
      S_IDLE: begin
        if (io.in_valid) begin
          addr_d    = io.alu_result;
          sdata_d   = io.rs2_data;
          op_d      = io.mem_op;
          rd_d      = io.rd_in;
          out_err_d = 1'b0;
          if (!(is_load(io.mem_op) || is_store(io.mem_op))) begin
            out_data_d = io.alu_result;
            state_d    = S_RESP;
          end else if (misaligned(io.mem_op, io.alu_result[1:0])) begin
            out_data_d = 32'd0;
            out_err_d  = 1'b1;
            state_d    = S_RESP;
          end else begin
            wdog_d  = 32'd0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        wdog_d = wdog_q + 32'd1;
        if (timeout_hit) begin
          out_data_d = 32'd0;
          out_err_d  = 1'b1;
          state_d    = S_RESP;
        end else if (io.mem_gnt) begin
          if (is_store(op_q)) begin
            out_data_d = 32'd0;
            state_d    = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        wdog_d = wdog_q + 32'd1;
        if (timeout_hit) begin
          out_data_d = 32'd0;
          out_err_d  = 1'b1;
          state_d    = S_RESP;
        end else if (io.mem_rvalid) begin
          out_data_d = load_val;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (io.out_ready) begin
          out_err_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= 32'd0;
      sdata_q    <= 32'd0;
      op_q       <= 4'd0;
      rd_q       <= 5'd0;
      out_data_q <= 32'd0;
      out_err_q  <= 1'b0;
      wdog_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      sdata_q    <= sdata_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
      wdog_q     <= wdog_d;
    end
  end

  assign req_active   = (state_q == S_REQ) && !timeout_hit;
  assign io.in_ready  = (state_q == S_IDLE);
  assign io.out_valid = (state_q == S_RESP);
  assign io.out_data  = out_data_q;
  assign io.out_rd    = rd_q;
  assign io.out_err   = out_err_q;
  assign io.mem_req   = req_active;
  assign io.mem_we    = req_active && is_store(op_q);
  assign io.mem_addr  = {addr_q[31:2], 2'b00};
  assign io.mem_wdata = wdata_lane;
  assign io.mem_wmask = (req_active && is_store(op_q)) ? wmask_lane : 4'b0000;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ysyx_25040105_lsu.sv
// Directed bench for the LSU: pass-through, loads, store lanes, misalignment,
// watchdog abort and asynchronous reset in the middle of a load.
module tb_ysyx_25040105_lsu;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] dbg_a, dbg_t;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_25040105_lsu_if bus_a ();
  ysyx_25040105_lsu_if bus_t ();

  ysyx_25040105_lsu dut (
    .clk(clk), .rst_n(rst_n), .io(bus_a), .dbg_state(dbg_a)
  );

  ysyx_25040105_lsu #(.TIMEOUT_CYC(4)) dut_t (
    .clk(clk), .rst_n(rst_n), .io(bus_t), .dbg_state(dbg_t)
  );

  // Load vectors: op, address, bus word, expected address, expected result.
  logic [3:0]  ld_op   [6] = '{4'b0001, 4'b0100, 4'b0010, 4'b0101, 4'b0001, 4'b0011};
  logic [31:0] ld_addr [6] = '{32'h8000_0003, 32'h8000_0003, 32'h8000_0002,
                               32'h8000_0002, 32'h8000_0001, 32'h8000_0004};
  logic [31:0] ld_word [6] = '{32'h80FF_0000, 32'h80FF_0000, 32'h9ABC_1234,
                               32'h9ABC_1234, 32'h0000_7F00, 32'hCAFE_F00D};
  logic [31:0] ld_ea   [6] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                               32'h8000_0000, 32'h8000_0000, 32'h8000_0004};
  logic [31:0] ld_exp  [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_9ABC,
                               32'h0000_9ABC, 32'h0000_007F, 32'hCAFE_F00D};

  task automatic idle_inputs();
    bus_a.in_valid = 1'b0; bus_a.alu_result = '0; bus_a.rs2_data = '0;
    bus_a.mem_op = '0; bus_a.rd_in = '0; bus_a.out_ready = 1'b1;
    bus_a.mem_gnt = 1'b0; bus_a.mem_rvalid = 1'b0; bus_a.mem_rdata = '0;
    bus_t.in_valid = 1'b0; bus_t.alu_result = '0; bus_t.rs2_data = '0;
    bus_t.mem_op = '0; bus_t.rd_in = '0; bus_t.out_ready = 1'b1;
    bus_t.mem_gnt = 1'b0; bus_t.mem_rvalid = 1'b0; bus_t.mem_rdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", bus_a.in_ready); end
    checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", bus_a.out_valid); end
    checks++; if (bus_a.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got=%b exp=0", bus_a.mem_req); end
    checks++; if (bus_a.mem_we !== 1'b0 || bus_a.mem_wmask !== 4'b0000) begin errors++; $display("FAIL rst_we_mask got=%b/%b exp=0/0000", bus_a.mem_we, bus_a.mem_wmask); end
    checks++; if (bus_a.out_data !== 32'd0 || bus_a.out_rd !== 5'd0 || bus_a.out_err !== 1'b0) begin errors++; $display("FAIL rst_out got=%h/%0d/%b exp=0/0/0", bus_a.out_data, bus_a.out_rd, bus_a.out_err); end
    checks++; if (bus_a.mem_addr !== 32'd0 || bus_a.mem_wdata !== 32'd0) begin errors++; $display("FAIL rst_bus got=%h/%h exp=0/0", bus_a.mem_addr, bus_a.mem_wdata); end
    checks++; if (dbg_a !== 2'd0 || dbg_t !== 2'd0) begin errors++; $display("FAIL rst_state got=%0d/%0d exp=0/0", dbg_a, dbg_t); end
    rst_n = 1'b1;
  endtask

  task automatic test_pass_through();
    @(negedge clk);
    bus_a.in_valid = 1'b1; bus_a.mem_op = 4'b0000; bus_a.alu_result = 32'h1234_5678;
    bus_a.rd_in = 5'd5; bus_a.out_ready = 1'b1;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    checks++; if (bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL pt_valid got=%b exp=1", bus_a.out_valid); end
    checks++; if (bus_a.out_data !== 32'h1234_5678) begin errors++; $display("FAIL pt_data got=%h exp=12345678", bus_a.out_data); end
    checks++; if (bus_a.out_rd !== 5'd5) begin errors++; $display("FAIL pt_rd got=%0d exp=5", bus_a.out_rd); end
    checks++; if (bus_a.mem_req !== 1'b0 || bus_a.in_ready !== 1'b0) begin errors++; $display("FAIL pt_req_rdy got=%b/%b exp=0/0", bus_a.mem_req, bus_a.in_ready); end
    @(negedge clk);
    checks++; if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL pt_done got=%b/%b exp=0/1", bus_a.out_valid, bus_a.in_ready); end
  endtask

  task automatic test_loads();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus_a.in_valid = 1'b1; bus_a.mem_op = ld_op[i]; bus_a.alu_result = ld_addr[i];
      bus_a.rd_in = 5'd7; bus_a.out_ready = 1'b1; bus_a.mem_gnt = 1'b1;
      @(negedge clk);
      bus_a.in_valid = 1'b0;
      bus_a.mem_rvalid = 1'b1; bus_a.mem_rdata = 32'h1111_1111;
      checks++; if (bus_a.mem_req !== 1'b1 || bus_a.mem_we !== 1'b0 || bus_a.mem_wmask !== 4'b0000) begin errors++; $display("FAIL ld%0d_req got=%b/%b/%b exp=1/0/0000", i, bus_a.mem_req, bus_a.mem_we, bus_a.mem_wmask); end
      checks++; if (bus_a.mem_addr !== ld_ea[i]) begin errors++; $display("FAIL ld%0d_addr got=%h exp=%h", i, bus_a.mem_addr, ld_ea[i]); end
      @(negedge clk);
      bus_a.mem_gnt = 1'b0; bus_a.mem_rvalid = 1'b0;
      checks++; if (bus_a.mem_req !== 1'b0 || bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL ld%0d_wait got=%b/%b exp=0/0", i, bus_a.mem_req, bus_a.out_valid); end
      @(negedge clk);
      bus_a.mem_rvalid = 1'b1; bus_a.mem_rdata = ld_word[i];
      @(negedge clk);
      bus_a.mem_rvalid = 1'b0; bus_a.mem_rdata = 32'h0;
      checks++; if (bus_a.out_valid !== 1'b1 || bus_a.out_err !== 1'b0) begin errors++; $display("FAIL ld%0d_valid got=%b/%b exp=1/0", i, bus_a.out_valid, bus_a.out_err); end
      checks++; if (bus_a.out_data !== ld_exp[i]) begin errors++; $display("FAIL ld%0d_data got=%h exp=%h", i, bus_a.out_data, ld_exp[i]); end
      @(negedge clk);
      checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL ld%0d_idle got=%b exp=1", i, bus_a.in_ready); end
    end
  endtask

  task automatic test_store_half_stall();
    @(negedge clk);
    bus_a.in_valid = 1'b1; bus_a.mem_op = 4'b1010; bus_a.alu_result = 32'h8000_0002;
    bus_a.rs2_data = 32'hAAAA_BEEF; bus_a.rd_in = 5'd3; bus_a.out_ready = 1'b1;
    bus_a.mem_gnt = 1'b0;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus_a.mem_req !== 1'b1 || bus_a.mem_we !== 1'b1) begin errors++; $display("FAIL sh_req%0d got=%b/%b exp=1/1", k, bus_a.mem_req, bus_a.mem_we); end
      checks++; if (bus_a.mem_addr !== 32'h8000_0000 || bus_a.mem_wdata !== 32'hBEEF_BEEF || bus_a.mem_wmask !== 4'b1100) begin errors++; $display("FAIL sh_fields%0d got=%h/%h/%b exp=80000000/beefbeef/1100", k, bus_a.mem_addr, bus_a.mem_wdata, bus_a.mem_wmask); end
      if (k == 3) bus_a.mem_gnt = 1'b1;
      @(negedge clk);
    end
    bus_a.mem_gnt = 1'b0;
    checks++; if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 32'd0 || bus_a.out_rd !== 5'd3) begin errors++; $display("FAIL sh_resp got=%b/%h/%0d exp=1/0/3", bus_a.out_valid, bus_a.out_data, bus_a.out_rd); end
    checks++; if (bus_a.mem_req !== 1'b0) begin errors++; $display("FAIL sh_req_drop got=%b exp=0", bus_a.mem_req); end
    @(negedge clk);
  endtask

  task automatic test_store_lanes();
    logic [31:0] st_addr [2];
    logic [31:0] st_data [2];
    logic [3:0]  st_op   [2];
    logic [31:0] st_ea   [2];
    logic [31:0] st_wd   [2];
    logic [3:0]  st_wm   [2];
    st_op[0] = 4'b1001; st_addr[0] = 32'h8000_0001; st_data[0] = 32'h1234_56A5;
    st_ea[0] = 32'h8000_0000; st_wd[0] = 32'hA5A5_A5A5; st_wm[0] = 4'b0010;
    st_op[1] = 4'b1011; st_addr[1] = 32'h8000_0008; st_data[1] = 32'hDEAD_BEEF;
    st_ea[1] = 32'h8000_0008; st_wd[1] = 32'hDEAD_BEEF; st_wm[1] = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus_a.in_valid = 1'b1; bus_a.mem_op = st_op[i]; bus_a.alu_result = st_addr[i];
      bus_a.rs2_data = st_data[i]; bus_a.rd_in = 5'd12; bus_a.mem_gnt = 1'b1;
      @(negedge clk);
      bus_a.in_valid = 1'b0;
      checks++; if (bus_a.mem_addr !== st_ea[i] || bus_a.mem_wdata !== st_wd[i] || bus_a.mem_wmask !== st_wm[i]) begin errors++; $display("FAIL st%0d_fields got=%h/%h/%b exp=%h/%h/%b", i, bus_a.mem_addr, bus_a.mem_wdata, bus_a.mem_wmask, st_ea[i], st_wd[i], st_wm[i]); end
      @(negedge clk);
      bus_a.mem_gnt = 1'b0;
      checks++; if (bus_a.out_valid !== 1'b1 || bus_a.out_rd !== 5'd12 || bus_a.out_err !== 1'b0) begin errors++; $display("FAIL st%0d_resp got=%b/%0d/%b exp=1/12/0", i, bus_a.out_valid, bus_a.out_rd, bus_a.out_err); end
      @(negedge clk);
    end
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    bus_a.in_valid = 1'b1; bus_a.mem_op = 4'b0011; bus_a.alu_result = 32'h8000_0001;
    bus_a.rd_in = 5'd9; bus_a.out_ready = 1'b0;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus_a.out_valid !== 1'b1 || bus_a.out_err !== 1'b1 || bus_a.out_data !== 32'd0 || bus_a.out_rd !== 5'd9) begin errors++; $display("FAIL mis_hold%0d got=%b/%b/%h/%0d exp=1/1/0/9", k, bus_a.out_valid, bus_a.out_err, bus_a.out_data, bus_a.out_rd); end
      checks++; if (bus_a.mem_req !== 1'b0 || bus_a.in_ready !== 1'b0) begin errors++; $display("FAIL mis_bus%0d got=%b/%b exp=0/0", k, bus_a.mem_req, bus_a.in_ready); end
      @(negedge clk);
    end
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus_a.out_valid !== 1'b0 || bus_a.out_err !== 1'b0) begin errors++; $display("FAIL mis_clear got=%b/%b exp=0/0", bus_a.out_valid, bus_a.out_err); end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    bus_t.in_valid = 1'b1; bus_t.mem_op = 4'b0011; bus_t.alu_result = 32'h8000_0010;
    bus_t.rd_in = 5'd4; bus_t.out_ready = 1'b1; bus_t.mem_gnt = 1'b1;
    @(negedge clk);
    bus_t.in_valid = 1'b0;
    checks++; if (bus_t.mem_req !== 1'b1) begin errors++; $display("FAIL to_req got=%b exp=1", bus_t.mem_req); end
    @(negedge clk);
    bus_t.mem_gnt = 1'b0;
    repeat (2) @(negedge clk);
    // Fourth bus cycle: the abort happens here and the rvalid must lose.
    checks++; if (bus_t.out_valid !== 1'b0 || bus_t.mem_req !== 1'b0) begin errors++; $display("FAIL to_pending got=%b/%b exp=0/0", bus_t.out_valid, bus_t.mem_req); end
    bus_t.mem_rvalid = 1'b1; bus_t.mem_rdata = 32'h1234_5678;
    @(negedge clk);
    bus_t.mem_rvalid = 1'b0;
    checks++; if (bus_t.out_valid !== 1'b1 || bus_t.out_err !== 1'b1 || bus_t.out_data !== 32'd0) begin errors++; $display("FAIL to_abort got=%b/%b/%h exp=1/1/0", bus_t.out_valid, bus_t.out_err, bus_t.out_data); end
    @(negedge clk);
    bus_t.mem_rvalid = 1'b1; bus_t.mem_rdata = 32'hFFFF_FFFF;
    checks++; if (bus_t.in_ready !== 1'b1 || bus_t.out_valid !== 1'b0) begin errors++; $display("FAIL to_idle got=%b/%b exp=1/0", bus_t.in_ready, bus_t.out_valid); end
    @(negedge clk);
    bus_t.mem_rvalid = 1'b0;
    checks++; if (bus_t.out_valid !== 1'b0 || bus_t.out_err !== 1'b0 || bus_t.mem_req !== 1'b0) begin errors++; $display("FAIL to_late_rvalid got=%b/%b/%b exp=0/0/0", bus_t.out_valid, bus_t.out_err, bus_t.mem_req); end
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk);
    bus_a.in_valid = 1'b1; bus_a.mem_op = 4'b0011; bus_a.alu_result = 32'h8000_0020;
    bus_a.rd_in = 5'd6; bus_a.out_ready = 1'b1; bus_a.mem_gnt = 1'b1;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    @(negedge clk);
    bus_a.mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus_a.in_ready !== 1'b1 || bus_a.out_valid !== 1'b0 || bus_a.mem_req !== 1'b0) begin errors++; $display("FAIL rm_ctrl got=%b/%b/%b exp=1/0/0", bus_a.in_ready, bus_a.out_valid, bus_a.mem_req); end
    checks++; if (bus_a.mem_addr !== 32'd0 || bus_a.out_rd !== 5'd0 || bus_a.out_data !== 32'd0) begin errors++; $display("FAIL rm_data got=%h/%0d/%h exp=0/0/0", bus_a.mem_addr, bus_a.out_rd, bus_a.out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    bus_a.mem_rvalid = 1'b1; bus_a.mem_rdata = 32'h5555_5555;
    @(negedge clk);
    bus_a.mem_rvalid = 1'b0;
    checks++; if (bus_a.in_ready !== 1'b1 || bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL rm_release got=%b/%b exp=1/0", bus_a.in_ready, bus_a.out_valid); end
    bus_a.in_valid = 1'b1; bus_a.mem_op = 4'b0011; bus_a.alu_result = 32'h8000_0024;
    bus_a.rd_in = 5'd11; bus_a.mem_gnt = 1'b1;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    checks++; if (bus_a.mem_req !== 1'b1 || bus_a.mem_addr !== 32'h8000_0024) begin errors++; $display("FAIL rm_lw_req got=%b/%h exp=1/80000024", bus_a.mem_req, bus_a.mem_addr); end
    @(negedge clk);
    bus_a.mem_gnt = 1'b0; bus_a.mem_rvalid = 1'b1; bus_a.mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus_a.mem_rvalid = 1'b0;
    checks++; if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 32'hCAFE_F00D || bus_a.out_rd !== 5'd11) begin errors++; $display("FAIL rm_lw_resp got=%b/%h/%0d exp=1/cafef00d/11", bus_a.out_valid, bus_a.out_data, bus_a.out_rd); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_loads();
    test_store_half_stall();
    test_store_lanes();
    test_misaligned();
    test_timeout();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
